// File: rtl/mem_arbiter_if.sv
// Two-requester port bundle for mem_arbiter, plus the shared memory side.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 32
);
  logic             req0, req1;
  logic             we0, we1;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_in;
  logic             mem_we;
  logic [WIDTH-1:0] mem_out;
  logic [31:0]      conflict_cnt;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_in, mem_we, conflict_cnt
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_in, mem_we, conflict_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single-port synchronous memory: port 0 has priority,
// port 1 gets one forced grant after STARVE_LIMIT consecutive denials.
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic {NORMAL, FORCED} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t           state;
  logic [3:0]       starve;
  logic             rpend, rsel;
  logic [31:0]      conf_q;
  logic             gnt0, gnt1;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  // Grants are combinational so a request is served in its own cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (state == FORCED) begin
        gnt1 = bus.req1;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1 & ~bus.req0;
      end
    end
  end

  assign sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.mem_addr = sel_addr;
  assign bus.mem_in   = sel_wdata;
  assign bus.mem_we   = (gnt0 & bus.we0) | (gnt1 & bus.we1);

  assign bus.rvalid0      = rpend & ~rsel;
  assign bus.rvalid1      = rpend &  rsel;
  assign bus.rdata0       = bus.mem_out;
  assign bus.rdata1       = bus.mem_out;
  assign bus.conflict_cnt = conf_q;

  // FORCED lasts exactly one cycle: either port 1 is granted or it has dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= NORMAL;
      starve <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (bus.req1 & ~gnt1) begin
            starve <= starve + 4'd1;
            if (starve + 4'd1 >= LIM) state <= FORCED;
          end else begin
            starve <= '0;
          end
        end
        FORCED: begin
          starve <= '0;
          state  <= NORMAL;
        end
        default: begin
          starve <= '0;
          state  <= NORMAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpend  <= 1'b0;
      rsel   <= 1'b0;
      conf_q <= '0;
    end else begin
      rpend <= (gnt0 & ~bus.we0) | (gnt1 & ~bus.we1);
      rsel  <= gnt1;
      if (bus.req0 & bus.req1 & (conf_q != 32'hFFFF_FFFF)) conf_q <= conf_q + 32'd1;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter AW, default 32: word-address width in bits; byte-to-word conversion is done by the requester.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive denied cycles of port 1 before it gets forced priority; legal range 1..15.
REQ-004 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  in  1: asynchronous, active-low reset (asserted when 0).
REQ-006 Ports req0/req1  in  1: access request, port 0 (data side) and port 1 (fetch/loader side).
REQ-007 Ports we0/we1  in  1: 1 = write, 0 = read.
REQ-008 Ports addr0/addr1  in  AW: word address.
REQ-009 Ports wdata0/wdata1  in  WIDTH: write data.
REQ-010 Ports gnt0/gnt1  out  1: access accepted this cycle.
REQ-011 Ports rvalid0/rvalid1  out  1: read data valid this cycle.
REQ-012 Ports rdata0/rdata1  out  WIDTH: read data.
REQ-013 Port mem_addr  out  AW: address to the shared single-port synchronous memory.
REQ-014 Port mem_in  out  WIDTH: write data to memory.
REQ-015 Port mem_we  out  1: memory write enable.
REQ-016 Port mem_out  in  WIDTH: memory read data, valid one cycle after the address.
REQ-017 Port conflict_cnt  out  32: count of cycles in which both ports requested.

Function
REQ-018 gnt0/gnt1 are combinational in the request cycle, one-hot or zero, and never both 1.
REQ-019 Default priority goes to port 0: gnt0 = req0 whenever forced-priority mode is off.
REQ-020 starve counter (4 bits): increments when req1 & ~gnt1; clears on gnt1 or when req1 = 0.
REQ-021 Forced-priority mode is active when starve >= STARVE_LIMIT; in that mode gnt1 = req1 and gnt0 = 0.
REQ-022 mem_addr, mem_in and mem_we come from the granted port; mem_we = gnt & we of that port.
REQ-023 With no grant: mem_we = 0 and mem_addr/mem_in hold the port 0 values.
REQ-024 A granted read sets registers rsel (port id) and rpend; in the next cycle the rvalid of port rsel = 1, and the rdata of that port = mem_out.
REQ-025 rvalid is a single-cycle pulse per granted read; a granted write produces no rvalid.
REQ-026 Back-to-back grants are allowed every cycle, so throughput is 1 access per cycle.
REQ-027 A read response and a new grant may occur in the same cycle, on either port.
REQ-028 rdata0/rdata1 are don't-care when the corresponding rvalid = 0; the implementation drives mem_out to both.
REQ-029 A requester holds req/we/addr/wdata stable until it sees gnt; a request is consumed in its grant cycle.
REQ-030 conflict_cnt increments when req0 & req1, and saturates at 32'hFFFF_FFFF.
REQ-031 The arbiter is a two-state priority FSM:
  NORMAL -> FORCED when starve reaches STARVE_LIMIT;
  FORCED -> NORMAL after exactly one gnt1, or when req1 drops.

Reset
REQ-032 While rst = 0: gnt0/gnt1/rvalid0/rvalid1/mem_we = 0, starve = 0, rpend = 0, conflict_cnt = 0, FSM = NORMAL.
REQ-033 Reset assertion is asynchronous; a read granted in the cycle before reset produces no rvalid.
REQ-034 After rst rises, the first grant is possible in the same cycle as the first req.

Verification
REQ-035 Scenario: req0 read addr 5 (mem[5] = 32'hCAFE), req1 idle -> gnt0 in cycle t; rvalid0 = 1 with rdata0 = 32'hCAFE in t+1; rvalid1 = 0.
REQ-036 Scenario: req0 and req1 held high continuously, STARVE_LIMIT = 4 -> gnt0 for 4 cycles, then gnt1 for 1 cycle, pattern repeats; conflict_cnt increments every cycle.
REQ-037 Scenario: port 1 write addr 7 data 32'h1234, then port 0 read addr 7 the next cycle -> mem_we = 1 only in the write cycle; rdata0 = 32'h1234 with rvalid0.
REQ-038 Scenario: alternating reads, port 0 in t and port 1 in t+1 -> rvalid0 in t+1 and rvalid1 in t+2, each carrying its own address's data.
REQ-039 Scenario: rst driven low mid-clock right after a granted read -> all outputs 0 immediately, no rvalid afterwards, conflict_cnt = 0.
REQ-040 Scenario: req1 alone for 10 cycles -> gnt1 every cycle, starve stays 0, FSM stays NORMAL.
